// File: rtl/cdc_req_sender.sv
// ============================================================================
// cdc_req_sender : source side of a four-phase req/ack bundled-data CDC link
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cdc_req_sender #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_a,
  output logic              done_p,
  output logic              timeout_p,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    req_q, req_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    acked_q, acked_d;
  logic                    done_q, done_d;
  logic                    tmo_q, tmo_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ack_s;
  logic                    tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_a};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  generate
    if (TIMEOUT_CYC != 0) begin : g_tmo
      assign tmo_hit = (cnt_q == C_CNT_LAST);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  // A still-high ack_s after a timeout abort would complete the next
  // transfer instantly, so accepting is held off until it clears.
  assign in_ready  = (state_q == IDLE) & ~ack_s;
  assign busy      = (state_q != IDLE);
  assign req       = req_q;
  assign data_out  = data_q;
  assign done_p    = done_q;
  assign timeout_p = tmo_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    acked_d = acked_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          acked_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack is checked first so it wins a same-cycle race with expiry.
        if (ack_s) begin
          req_d   = 1'b0;
          acked_d = 1'b1;
          state_d = ACK_LOW;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ACK_LOW;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK_LOW: begin
        if (!ack_s) begin
          done_d  = acked_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      acked_q <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      acked_q <= acked_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdc_req_sender.sv
// ============================================================================
// tb_cdc_req_sender : directed self-checking bench for cdc_req_sender
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_cdc_req_sender;

  logic       clk;
  logic       rst_n;

  logic       va, ra, reqa, acka, donea, tmoa, busya;
  logic [7:0] da_in, da_out;
  logic       vb, rb, reqb, ackb, doneb, tmob, busyb;
  logic [7:0] db_in, db_out;

  int n_checks;
  int n_errors;
  logic tmo_seen;

  cdc_req_sender #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT_CYC(5)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ra), .in_data(da_in),
    .req(reqa), .data_out(da_out), .ack_a(acka), .done_p(donea),
    .timeout_p(tmoa), .busy(busya)
  );

  cdc_req_sender #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT_CYC(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rb), .in_data(db_in),
    .req(reqb), .data_out(db_out), .ack_a(ackb), .done_p(doneb),
    .timeout_p(tmob), .busy(busyb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instant responder on u_a, called just after the accept edge (edge 0).
  task automatic complete_a();
    tick();
    acka = 1'b1;
    repeat (4) tick();
    acka = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    tmo_seen = 1'b0;
    rst_n = 1'b1;
    va = 1'b0; da_in = 8'h00; acka = 1'b0;
    vb = 1'b0; db_in = 8'h00; ackb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req",      {31'd0, reqa},  32'd0);
    chk("rst_data",     {24'd0, da_out}, 32'd0);
    chk("rst_done",     {31'd0, donea}, 32'd0);
    chk("rst_timeout",  {31'd0, tmoa},  32'd0);
    chk("rst_busy",     {31'd0, busya}, 32'd0);
    chk("rst_ready",    {31'd0, ra},    32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // Basic transfer
    va = 1'b1; da_in = 8'hA5;
    tick();
    va = 1'b0;
    chk("t1_req_e0",  {31'd0, reqa},  32'd1);
    chk("t1_data_e0", {24'd0, da_out}, 32'hA5);
    chk("t1_busy_e0", {31'd0, busya}, 32'd1);
    chk("t1_rdy_e0",  {31'd0, ra},    32'd0);
    tick();
    acka = 1'b1;
    tick(); tick();
    chk("t1_req_e3",  {31'd0, reqa},  32'd1);
    tick();
    chk("t1_req_e4",  {31'd0, reqa},  32'd0);
    chk("t1_busy_e4", {31'd0, busya}, 32'd1);
    tick();
    acka = 1'b0;
    tick(); tick();
    chk("t1_done_e7", {31'd0, donea}, 32'd0);
    chk("t1_busy_e7", {31'd0, busya}, 32'd1);
    tick();
    chk("t1_done_e8", {31'd0, donea}, 32'd1);
    chk("t1_busy_e8", {31'd0, busya}, 32'd0);
    chk("t1_rdy_e8",  {31'd0, ra},    32'd1);
    tick();
    chk("t1_done_e9", {31'd0, donea}, 32'd0);

    // Back-to-back transfers with in_valid held
    va = 1'b1; da_in = 8'h01;
    tick();
    da_in = 8'h02;
    chk("t2_data_e0", {24'd0, da_out}, 32'h01);
    tick();
    acka = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      tick();
      if (i == 5) acka = 1'b0;
      chk("t2_data_hold", {24'd0, da_out}, 32'h01);
    end
    chk("t2_done_e8", {31'd0, donea}, 32'd1);
    chk("t2_rdy_e8",  {31'd0, ra},    32'd1);
    tick();
    va = 1'b0;
    chk("t2_req_e9",  {31'd0, reqa},  32'd1);
    chk("t2_data_e9", {24'd0, da_out}, 32'h02);
    chk("t2_done_e9", {31'd0, donea}, 32'd0);
    complete_a();
    chk("t2_done2",   {31'd0, donea}, 32'd1);
    tick();

    // Timeout with no acknowledge
    va = 1'b1; da_in = 8'h5A;
    tick();
    va = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t3_req_hold", {31'd0, reqa}, 32'd1);
      chk("t3_tmo_low",  {31'd0, tmoa}, 32'd0);
    end
    tick();
    chk("t3_req_e5",  {31'd0, reqa},  32'd0);
    chk("t3_tmo_e5",  {31'd0, tmoa},  32'd1);
    chk("t3_done_e5", {31'd0, donea}, 32'd0);
    tick();
    chk("t3_tmo_e6",  {31'd0, tmoa},  32'd0);
    chk("t3_busy_e6", {31'd0, busya}, 32'd0);
    chk("t3_rdy_e6",  {31'd0, ra},    32'd1);
    chk("t3_done_e6", {31'd0, donea}, 32'd0);

    // Stale ack after the abort blocks acceptance
    acka = 1'b1;
    tick(); tick();
    chk("t4_rdy_stale", {31'd0, ra}, 32'd0);
    va = 1'b1; da_in = 8'h3C;
    tick();
    chk("t4_req_blocked",  {31'd0, reqa},  32'd0);
    chk("t4_busy_blocked", {31'd0, busya}, 32'd0);
    acka = 1'b0;
    tick();
    chk("t4_rdy_e10", {31'd0, ra}, 32'd0);
    tick();
    chk("t4_rdy_e11", {31'd0, ra},   32'd1);
    chk("t4_req_e11", {31'd0, reqa}, 32'd0);
    tick();
    va = 1'b0;
    chk("t4_req_acc",  {31'd0, reqa},  32'd1);
    chk("t4_data_acc", {24'd0, da_out}, 32'h3C);
    complete_a();
    chk("t4_done", {31'd0, donea}, 32'd1);
    tick();

    // Ack rise races counter expiry (TIMEOUT_CYC=4)
    vb = 1'b1; db_in = 8'h77;
    tick();
    vb = 1'b0;
    tick();
    ackb = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      tick();
      tmo_seen = tmo_seen | tmob;
      if (i == 4) begin
        chk("t5_req_e4",  {31'd0, reqb},  32'd0);
        chk("t5_busy_e4", {31'd0, busyb}, 32'd1);
      end
      if (i == 5) ackb = 1'b0;
      if (i == 7) chk("t5_done_e7", {31'd0, doneb}, 32'd0);
    end
    chk("t5_done_e8",  {31'd0, doneb},    32'd1);
    chk("t5_no_tmo",   {31'd0, tmo_seen}, 32'd0);
    tick();

    // Asynchronous reset during a request
    va = 1'b1; da_in = 8'hFF;
    tick();
    va = 1'b0;
    chk("t6_req_pre",  {31'd0, reqa},  32'd1);
    chk("t6_data_pre", {24'd0, da_out}, 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_async",  {31'd0, reqa},  32'd0);
    chk("t6_data_async", {24'd0, da_out}, 32'd0);
    chk("t6_busy_async", {31'd0, busya}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t6_rdy_post",  {31'd0, ra},    32'd1);
    chk("t6_busy_post", {31'd0, busya}, 32'd0);
    chk("t6_req_post",  {31'd0, reqa},  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
